// File: rtl/div4_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : div4_pkg
//  Description : Shared types and constants for the divide-by-four counter
//                and its direction-switch conditioning logic.
//                - debounce_state_t : debounce FSM state encoding
//                - DIR_UP / DIR_DOWN: direction levels seen by the counter
//                - DEBOUNCE_CYCLES_* : stable-sample counts for sim / hardware
//  Revision    : 1.0 - initial release
// ============================================================================
package div4_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } debounce_state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Short debounce for simulation; 10 ms at 50 MHz on the board.
  localparam int DEBOUNCE_CYCLES_SIM = 4;
  localparam int DEBOUNCE_CYCLES_HW  = 500000;

endpackage : div4_pkg
`default_nettype wire

// File: rtl/direction_debounce_if.sv
`default_nettype none
// ============================================================================
//  Interface   : direction_debounce_if
//  Description : Bundles the raw switch input and the conditioned outputs of
//                the direction debouncer.
//                button_in    : raw switch level (asynchronous, bouncing)
//                signal_out   : debounced direction level
//                dir_changed  : one-cycle pulse when signal_out changes
//                glitch_count : saturating count of rejected transitions
//                master : the debouncer (consumes button_in, drives the rest)
//                slave  : the environment (switch source and counter side)
//  Revision    : 1.0 - initial release
// ============================================================================
interface direction_debounce_if #(
  parameter int GLITCH_W = 8
);

  logic                button_in;
  logic                signal_out;
  logic                dir_changed;
  logic [GLITCH_W-1:0] glitch_count;

  modport master (
    input  button_in,
    output signal_out,
    output dir_changed,
    output glitch_count
  );

  modport slave (
    output button_in,
    input  signal_out,
    input  dir_changed,
    input  glitch_count
  );

endinterface : direction_debounce_if
`default_nettype wire

// File: rtl/bit_synchronizer.sv
`default_nettype none
// ============================================================================
//  Module      : bit_synchronizer
//  Description : N-flop synchroniser chain for a single asynchronous bit.
//                All flops reset asynchronously to 0.
//                clk   : destination clock
//                reset : asynchronous, active-high reset
//                d_i   : asynchronous input bit
//                q_o   : synchronised output (STAGES edges of latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic d_i,
  output logic      q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule : bit_synchronizer
`default_nettype wire

// File: rtl/direction_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : direction_debounce
//  Description : Synchronises and debounces the raw direction switch feeding
//                the divide-by-four up/down counter (0 = up, 1 = down).
//                clk   : system clock
//                reset : asynchronous, active-high reset
//                dir_if (master modport):
//                  button_in    in  raw switch level
//                  signal_out   out debounced direction
//                  dir_changed  out one-cycle pulse on direction change
//                  glitch_count out saturating rejected-transition count
//  Revision    : 1.0 - initial release
// ============================================================================
module direction_debounce
  import div4_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
  parameter int GLITCH_W        = 8
) (
  input  wire logic            clk,
  input  wire logic            reset,
  direction_debounce_if.master dir_if
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_MAX    = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("direction_debounce: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("direction_debounce: DEBOUNCE_CYCLES must be >= 1");
    end
  endgenerate

  logic s;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (dir_if.button_in),
    .q_o   (s)
  );

  debounce_state_t     state_q,  state_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic                out_q,    out_d;
  logic                chg_q,    chg_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= STABLE_LOW;
      cnt_q    <= '0;
      out_q    <= DIR_UP;
      chg_q    <= 1'b0;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      chg_q    <= chg_d;
      glitch_q <= glitch_d;
    end
  end

  // cnt counts synced samples of the new level seen so far, including the
  // one that left the stable state; the change is accepted on the sample
  // after cnt reaches DEBOUNCE_CYCLES, so cnt never wraps.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    chg_d    = 1'b0;
    glitch_d = glitch_q;

    case (state_q)
      STABLE_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end

      WAIT_HIGH: begin
        if (!s) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
          if (glitch_q != GLITCH_MAX) glitch_d = glitch_q + GLITCH_W'(1);
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
          out_d   = DIR_DOWN;
          chg_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      STABLE_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end

      WAIT_LOW: begin
        if (s) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
          if (glitch_q != GLITCH_MAX) glitch_d = glitch_q + GLITCH_W'(1);
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
          out_d   = DIR_UP;
          chg_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign dir_if.signal_out   = out_q;
  assign dir_if.dir_changed  = chg_q;
  assign dir_if.glitch_count = glitch_q;

endmodule : direction_debounce
`default_nettype wire
